msg_request_dispatcher: RTL and testbench
=========================================

// Module: msg_request_dispatcher
// PURPOSE
//  N-thread front end between EU message/breakpoint sources and the messenger microcontroller request bus.
//  Queues per-thread message parameters and keeps breakpoint requests sticky.
//  Raises two summary requests, arbitrates round-robin per class on acknowledge,
//  and presents the granted thread index and parameter one cycle later.
//  Generalises the fixed 4-thread, queue-less capture with FIFO depth, thread count and overflow reporting.
// PARAMETERS
//  THREADS  4   number of EU threads, 2..16
//  PW       64  message parameter width (index+parameter dword)
//  DEPTH    4   per-thread message queue depth, power of 2, >=2
//  TW       $clog2(THREADS)  derived thread index width (localparam)
// PORTS
//  CLK       in   1             clock, all logic on posedge
//  RESET     in   1             synchronous, active-high reset
//  EUREQ     in   THREADS       per-thread message push strobe (1 cycle)
//  EUPARAM   in   THREADS x PW  per-thread message parameter, sampled with EUREQ
//  EUFULL    out  THREADS       per-thread queue full
//  BKPT      in   THREADS       per-thread breakpoint request pulse
//  REQ       out  2             [0] any message queued, [1] any breakpoint pending
//  ACK       in   2             1-cycle grant from microcontroller, bit per REQ bit
//  VALID     out  1             pulse: THREAD/PARAM/KIND updated
//  KIND      out  1             0 message grant, 1 breakpoint grant
//  THREAD    out  TW            granted thread index
//  PARAM     out  PW            dequeued message parameter (unchanged on breakpoint grant)
//  OVERFLOW  out  THREADS       sticky: push attempted while full
//  CLROVF    in   1             clears OVERFLOW (all bits)
// BEHAVIOUR
//  Reset (RESET=1 at posedge):
//   - All queues are emptied and breakpoint flags cleared.
//   - RR pointers go to 0.
//   - Outputs: REQ=0, VALID=0, KIND=0, THREAD=0, PARAM=0, OVERFLOW=0, EUFULL=0.
//   - A reset mid-grant discards the grant. VALID is not raised.
//  Push:
//   - EUREQ[t] at edge n writes EUPARAM[t] into queue t.
//   - REQ[0] is high from n+1 (registered).
//   - Push into a full queue is dropped and sets OVERFLOW[t].
//   - Exception: a push coinciding with a pop of the same thread is accepted.
//  Breakpoint:
//   - BKPT[t] sets flag t. Repeats while pending merge.
//   - REQ[1] = |flags, registered.
//  Grant:
//   - ACK[0] with REQ[0]=1: the RR message arbiter picks the first non-empty queue at or after the msg pointer.
//     The head is popped. At n+1: VALID=1, KIND=0, THREAD=t, PARAM=head.
//     The msg pointer becomes t+1 mod THREADS.
//   - ACK[1] with REQ[1]=1: the RR breakpoint arbiter picks the first set flag at or after the bkpt pointer.
//     The flag is cleared. At n+1: VALID=1, KIND=1, THREAD=t. PARAM holds.
//   - ACK[1] and ACK[0] together: the breakpoint wins. ACK[0] is ignored and no pop occurs.
//   - ACK on a class with nothing pending: ignored. No VALID, no pointer change.
//   - BKPT[t] in the same cycle as flag t being granted: the flag stays set (set wins).
//   - VALID is a 1-cycle pulse. THREAD/PARAM/KIND hold until the next grant.
//  Queue:
//   - Per thread: a circular buffer with TW-independent ptrs of $clog2(DEPTH)+1 bits.
//   - Full when the MSBs differ and the rest are equal. Pointers wrap naturally.
//   - EUFULL[t] is registered and reflects the state after this cycle's push/pop.
//  OVERFLOW:
//   - CLROVF clears it.
//   - CLROVF coinciding with a new overflow: the bit stays set.
//  REQ:
//   - Deasserts the cycle after the last message/flag is consumed.
//   - The microcontroller must not re-ACK a class in the cycle immediately following its ACK.
// STRUCTURE
//  Package msg_dispatch_pkg:
//   - localparam KIND_MSG=1'b0, KIND_BKPT=1'b1.
//   - function rr_pick(req, ptr) returns a one-hot grant.
//  Sub-module rr_arbiter #(N):
//   - inputs REQ[N], ADV. Outputs SEL one-hot, IDX.
//   - Internal pointer advances to IDX+1 on ADV.
//   - Two instances: message class and breakpoint class.
//  Queues are a generate loop of register arrays in this module (no RAM inference needed).
// TESTING
//  1. Single push: RESET, EUREQ[2] with PARAM=64'hA5 at n.
//     -> REQ=01 at n+1. ACK=01 at n+2. VALID, KIND=0, THREAD=2, PARAM=A5 at n+3. REQ=00 at n+3.
//  2. Round robin: push threads 0,1,3 once each, ACK[0] x3 spaced 2 cycles.
//     -> THREAD sequence 0,1,3. Repeat with all 4 threads -> 0,1,2,3, then wraps to 0.
//  3. Full/overflow: DEPTH=4, 5 pushes to thread 1.
//     -> EUFULL[1]=1 after the 4th, OVERFLOW[1]=1 after the 5th.
//     Drain 4 -> values in push order, 5th absent. CLROVF -> OVERFLOW=0.
//  4. Push+pop when full: thread 0 full, EUREQ[0] with ACK[0] selecting 0 in the same cycle.
//     -> no OVERFLOW, EUFULL[0] stays 1, FIFO order preserved.
//  5. Collision: flags 1 and 3 pending plus queued message, ACK=11.
//     -> KIND=1, THREAD=1, no pop. BKPT[1] reasserted on the grant cycle -> REQ[1] stays 1.
//  6. Reset mid-op: queues non-empty, RESET asserted in the same cycle as ACK=01.
//     -> no VALID, REQ=00, EUFULL=0 next cycle. THREADS=8 regression reruns 2 -> 0..7 order.

Source files
------------

// File: rtl/msg_dispatch_pkg.sv
// Shared constants and round-robin pick helper for the message request dispatcher.
package msg_dispatch_pkg;

  localparam logic KIND_MSG  = 1'b0;
  localparam logic KIND_BKPT = 1'b1;

  localparam int unsigned MAX_THREADS = 16;

  // One-hot grant of the first set req bit at or after ptr, scanning n entries circularly.
  function automatic logic [MAX_THREADS-1:0] rr_pick(input logic [MAX_THREADS-1:0] req,
                                                     input logic [3:0]             ptr,
                                                     input int unsigned            n);
    logic [MAX_THREADS-1:0] gnt;
    logic                   found;
    int unsigned            j;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_THREADS; i++) begin
      j = 32'(ptr) + i;
      if (j >= n) j = j - n;
      if (i < n && !found && req[j[3:0]]) begin
        gnt[j[3:0]] = 1'b1;
        found       = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after an internal pointer.
module rr_arbiter
  import msg_dispatch_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [N-1:0]  REQ,
  input  logic          ADV,
  output logic [N-1:0]  SEL,
  output logic [IW-1:0] IDX
);

  logic [IW-1:0]          ptr_q;
  logic [MAX_THREADS-1:0] req_ext;
  logic [3:0]             ptr_ext;
  logic [MAX_THREADS-1:0] gnt;
  logic                   unused_gnt;

  // Pointer moves past the winner only when the grant is actually taken.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_q <= '0;
    end else if (ADV) begin
      ptr_q <= (IDX == IW'(N - 1)) ? '0 : IDX + IW'(1);
    end
  end

  // Widen to the helper's fixed width, pick, then encode the one-hot winner.
  always_comb begin
    req_ext            = '0;
    req_ext[N-1:0]     = REQ;
    ptr_ext            = '0;
    ptr_ext[IW-1:0]    = ptr_q;
    gnt                = rr_pick(req_ext, ptr_ext, N);
    SEL                = gnt[N-1:0];
    IDX                = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (SEL[i]) IDX = IW'(i);
    end
  end

  // Upper grant bits are always zero when N < MAX_THREADS.
  assign unused_gnt = ^gnt;

endmodule

// File: rtl/msg_request_dispatcher.sv
// N-thread front end: per-thread message queues, sticky breakpoint flags, RR grant to the uC.
module msg_request_dispatcher
  import msg_dispatch_pkg::*;
#(
  parameter  int unsigned THREADS = 4,
  parameter  int unsigned PW      = 64,
  parameter  int unsigned DEPTH   = 4,
  localparam int unsigned TW      = $clog2(THREADS)
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [THREADS-1:0]           EUREQ,
  input  logic [THREADS-1:0][PW-1:0]   EUPARAM,
  output logic [THREADS-1:0]           EUFULL,
  input  logic [THREADS-1:0]           BKPT,
  output logic [1:0]                   REQ,
  input  logic [1:0]                   ACK,
  output logic                         VALID,
  output logic                         KIND,
  output logic [TW-1:0]                THREAD,
  output logic [PW-1:0]                PARAM,
  output logic [THREADS-1:0]           OVERFLOW,
  input  logic                         CLROVF
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [THREADS-1:0] nonempty, full, pop, push_ok, ovf_set;
  logic [PW-1:0]      head [THREADS];
  logic [THREADS-1:0] flags_q, flags_d, ovf_q, ovf_d;
  logic [THREADS-1:0] msg_sel, bkpt_sel;
  logic [TW-1:0]      msg_idx, bkpt_idx;
  logic               msg_grant, bkpt_grant;
  logic               valid_q, kind_q;
  logic [TW-1:0]      thread_q;
  logic [PW-1:0]      param_q;

  // Breakpoint class wins a simultaneous acknowledge; ACKs with nothing pending are ignored.
  always_comb begin
    bkpt_grant = ACK[1] & (|flags_q);
    msg_grant  = ACK[0] & (|nonempty) & ~bkpt_grant;
    pop        = msg_grant ? msg_sel : '0;
    // A push into a full queue is fine when the same queue is popped this cycle.
    push_ok    = EUREQ & (~full | pop);
    ovf_set    = EUREQ & full & ~pop;
    flags_d    = (flags_q & ~(bkpt_grant ? bkpt_sel : '0)) | BKPT;
    ovf_d      = (ovf_q & {THREADS{~CLROVF}}) | ovf_set;
  end

  for (genvar t = 0; t < THREADS; t++) begin : g_queue
    logic [PW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q, rptr_q;

    // Extra pointer MSB distinguishes full from empty.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push_ok[t]) wptr_q <= wptr_q + (AW + 1)'(1);
        if (pop[t])     rptr_q <= rptr_q + (AW + 1)'(1);
      end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge CLK) begin
      if (push_ok[t]) mem_q[wptr_q[AW-1:0]] <= EUPARAM[t];
    end

    assign nonempty[t] = (wptr_q != rptr_q);
    assign full[t]     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head[t]     = mem_q[rptr_q[AW-1:0]];
  end

  rr_arbiter #(.N(THREADS)) u_msg_arb (
    .CLK   (CLK),
    .RESET (RESET),
    .REQ   (nonempty),
    .ADV   (msg_grant),
    .SEL   (msg_sel),
    .IDX   (msg_idx)
  );

  rr_arbiter #(.N(THREADS)) u_bkpt_arb (
    .CLK   (CLK),
    .RESET (RESET),
    .REQ   (flags_q),
    .ADV   (bkpt_grant),
    .SEL   (bkpt_sel),
    .IDX   (bkpt_idx)
  );

  // Sticky breakpoint flags and overflow bits; set beats clear in both.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      flags_q <= '0;
      ovf_q   <= '0;
    end else begin
      flags_q <= flags_d;
      ovf_q   <= ovf_d;
    end
  end

  // Grant result register: VALID pulses, THREAD/KIND/PARAM hold between grants.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q  <= 1'b0;
      kind_q   <= KIND_MSG;
      thread_q <= '0;
      param_q  <= '0;
    end else begin
      valid_q <= msg_grant | bkpt_grant;
      if (bkpt_grant) begin
        kind_q   <= KIND_BKPT;
        thread_q <= bkpt_idx;
      end else if (msg_grant) begin
        kind_q   <= KIND_MSG;
        thread_q <= msg_idx;
        param_q  <= head[msg_idx];
      end
    end
  end

  assign REQ      = {|flags_q, |nonempty};
  assign EUFULL   = full;
  assign OVERFLOW = ovf_q;
  assign VALID    = valid_q;
  assign KIND     = kind_q;
  assign THREAD   = thread_q;
  assign PARAM    = param_q;

endmodule

// File: tb/tb_msg_request_dispatcher.sv
// Directed bench for msg_request_dispatcher (4-thread main instance, 8-thread regression).
module tb_msg_request_dispatcher;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [3:0]       EUREQ, BKPT, EUFULL, OVERFLOW;
  logic [3:0][63:0] EUPARAM;
  logic [1:0]       ACK, REQ;
  logic             CLROVF, VALID, KIND;
  logic [1:0]       THREAD;
  logic [63:0]      PARAM;

  logic [7:0]       eureq8, bkpt8, eufull8, ovf8;
  logic [7:0][63:0] euparam8;
  logic [1:0]       ack8, req8;
  logic             valid8, kind8;
  logic [2:0]       thread8;
  logic [63:0]      param8;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  msg_request_dispatcher #(.THREADS(4), .PW(64), .DEPTH(4)) u_dut (
    .CLK(CLK), .RESET(RESET), .EUREQ(EUREQ), .EUPARAM(EUPARAM), .EUFULL(EUFULL),
    .BKPT(BKPT), .REQ(REQ), .ACK(ACK), .VALID(VALID), .KIND(KIND), .THREAD(THREAD),
    .PARAM(PARAM), .OVERFLOW(OVERFLOW), .CLROVF(CLROVF)
  );

  msg_request_dispatcher #(.THREADS(8), .PW(64), .DEPTH(4)) u_dut8 (
    .CLK(CLK), .RESET(RESET), .EUREQ(eureq8), .EUPARAM(euparam8), .EUFULL(eufull8),
    .BKPT(bkpt8), .REQ(req8), .ACK(ack8), .VALID(valid8), .KIND(kind8), .THREAD(thread8),
    .PARAM(param8), .OVERFLOW(ovf8), .CLROVF(1'b0)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are read at the same point.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic push(input int t, input logic [63:0] val);
    EUREQ[t]   = 1'b1;
    EUPARAM[t] = val;
    tick();
    EUREQ = '0;
  endtask

  // Issue one ACK, check the granted result, then leave an idle cycle.
  task automatic grant(input string tag, input logic [1:0] a, input logic kind,
                       input logic [1:0] thr, input logic [63:0] prm);
    ACK = a;
    tick();
    ACK = '0;
    check_eq({tag, ".valid"}, 64'(VALID), 64'd1);
    check_eq({tag, ".kind"}, 64'(KIND), 64'(kind));
    check_eq({tag, ".thread"}, 64'(THREAD), 64'(thr));
    check_eq({tag, ".param"}, PARAM, prm);
    tick();
  endtask

  initial begin
    RESET = 1'b0; EUREQ = '0; EUPARAM = '0; BKPT = '0; ACK = '0; CLROVF = 1'b0;
    eureq8 = '0; euparam8 = '0; bkpt8 = '0; ack8 = '0;
    #2;
    do_reset();

    check_eq("rst.req", 64'(REQ), 64'd0);
    check_eq("rst.valid", 64'(VALID), 64'd0);
    check_eq("rst.thread", 64'(THREAD), 64'd0);
    check_eq("rst.param", PARAM, 64'd0);
    check_eq("rst.eufull", 64'(EUFULL), 64'd0);
    check_eq("rst.ovf", 64'(OVERFLOW), 64'd0);

    // 1. single push
    push(2, 64'hA5);
    check_eq("t1.req", 64'(REQ), 64'd1);
    ACK = 2'b01;
    tick();
    ACK = '0;
    check_eq("t1.valid", 64'(VALID), 64'd1);
    check_eq("t1.kind", 64'(KIND), 64'd0);
    check_eq("t1.thread", 64'(THREAD), 64'd2);
    check_eq("t1.param", PARAM, 64'hA5);
    check_eq("t1.req_low", 64'(REQ), 64'd0);
    tick();
    check_eq("t1.valid_pulse", 64'(VALID), 64'd0);
    check_eq("t1.thread_hold", 64'(THREAD), 64'd2);

    // 2. round robin
    do_reset();
    push(0, 64'h20); push(1, 64'h21); push(3, 64'h23);
    grant("t2.a", 2'b01, 1'b0, 2'd0, 64'h20);
    grant("t2.b", 2'b01, 1'b0, 2'd1, 64'h21);
    grant("t2.c", 2'b01, 1'b0, 2'd3, 64'h23);
    EUREQ = 4'hF;
    for (int t = 0; t < 4; t++) EUPARAM[t] = 64'h30 + 64'(t);
    tick();
    EUREQ = '0;
    for (int t = 0; t < 4; t++) grant("t2.all", 2'b01, 1'b0, 2'(t), 64'h30 + 64'(t));
    EUREQ = 4'b0101;
    EUPARAM[0] = 64'h40;
    EUPARAM[2] = 64'h42;
    tick();
    EUREQ = '0;
    grant("t2.wrap0", 2'b01, 1'b0, 2'd0, 64'h40);
    grant("t2.wrap2", 2'b01, 1'b0, 2'd2, 64'h42);

    // 3. full / overflow
    do_reset();
    for (int i = 0; i < 4; i++) push(1, 64'h10 + 64'(i));
    check_eq("t3.full", 64'(EUFULL), 64'b0010);
    check_eq("t3.no_ovf", 64'(OVERFLOW), 64'd0);
    push(1, 64'h14);
    check_eq("t3.ovf", 64'(OVERFLOW), 64'b0010);
    for (int i = 0; i < 4; i++) grant("t3.drain", 2'b01, 1'b0, 2'd1, 64'h10 + 64'(i));
    check_eq("t3.empty_req", 64'(REQ), 64'd0);
    check_eq("t3.empty_full", 64'(EUFULL), 64'd0);
    CLROVF = 1'b1;
    tick();
    CLROVF = 1'b0;
    check_eq("t3.clrovf", 64'(OVERFLOW), 64'd0);

    // 4. push + pop on a full queue
    do_reset();
    for (int i = 0; i < 4; i++) push(0, 64'h50 + 64'(i));
    EUREQ[0] = 1'b1;
    EUPARAM[0] = 64'h54;
    ACK = 2'b01;
    tick();
    EUREQ = '0;
    ACK = '0;
    check_eq("t4.param", PARAM, 64'h50);
    check_eq("t4.no_ovf", 64'(OVERFLOW), 64'd0);
    check_eq("t4.full", 64'(EUFULL), 64'b0001);
    tick();
    for (int i = 1; i < 5; i++) grant("t4.order", 2'b01, 1'b0, 2'd0, 64'h50 + 64'(i));

    // 5. collision and set-wins on breakpoint flags
    do_reset();
    push(2, 64'h55);
    BKPT = 4'b1010;
    tick();
    BKPT = '0;
    check_eq("t5.req", 64'(REQ), 64'b11);
    BKPT = 4'b0010;
    ACK = 2'b11;
    tick();
    BKPT = '0;
    ACK = '0;
    check_eq("t5.kind", 64'(KIND), 64'd1);
    check_eq("t5.thread", 64'(THREAD), 64'd1);
    check_eq("t5.param_hold", PARAM, 64'd0);
    check_eq("t5.req_kept", 64'(REQ), 64'b11);
    tick();
    grant("t5.msg", 2'b01, 1'b0, 2'd2, 64'h55);
    ACK = 2'b01;
    tick();
    ACK = '0;
    check_eq("t5.empty_ack", 64'(VALID), 64'd0);
    tick();
    grant("t5.bk3", 2'b10, 1'b1, 2'd3, 64'h55);
    grant("t5.bk1", 2'b10, 1'b1, 2'd1, 64'h55);
    check_eq("t5.req_done", 64'(REQ), 64'd0);

    // 6. reset coinciding with an ACK
    do_reset();
    push(1, 64'h61); push(1, 64'h62); push(3, 64'h63);
    RESET = 1'b1;
    ACK = 2'b01;
    tick();
    RESET = 1'b0;
    ACK = '0;
    check_eq("t6.valid", 64'(VALID), 64'd0);
    check_eq("t6.req", 64'(REQ), 64'd0);
    check_eq("t6.eufull", 64'(EUFULL), 64'd0);
    check_eq("t6.thread", 64'(THREAD), 64'd0);

    // 8-thread round robin order
    eureq8 = 8'hFF;
    for (int t = 0; t < 8; t++) euparam8[t] = 64'h100 + 64'(t);
    tick();
    eureq8 = '0;
    for (int t = 0; t < 8; t++) begin
      ack8 = 2'b01;
      tick();
      ack8 = '0;
      check_eq("t8.valid", 64'(valid8), 64'd1);
      check_eq("t8.thread", 64'(thread8), 64'(t));
      check_eq("t8.param", param8, 64'h100 + 64'(t));
      tick();
    end
    check_eq("t8.req", 64'(req8), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
